decode_stage: RTL

- Registered, handshaked RV32I instruction-decode pipeline stage: the generalised successor of the combinational decoder.
- Sits between fetch (IF/ID valid/ready) and execute. It decodes one instruction per cycle into a registered control bundle (the ID/EX register).
- Adds an optional M-extension decode, illegal-instruction detection, load-use stall insertion, flush and back-pressure.

---
 rtl/decode_pkg.sv | 93 +++++++++
 rtl/decode_comb.sv | 144 ++++++++++++++
 rtl/decode_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I(M) decode constants, control bundle types and helpers.
// Imported by the decode combinational core and the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        reg_write;
    logic [1:0]  result_mux;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_mask;
    logic        branch;
    logic [2:0]  branch_op;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } id_ex_t;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz
  );
    case (sz)
      2'b00:   lane_mask = MASK_B;
      2'b01:   lane_mask = MASK_H;
      2'b10:   lane_mask = MASK_W;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [4:0] m_alu_op(
    input logic [2:0] f3
  );
    unique case (f3)
      3'b000: m_alu_op = ALU_MUL;
      3'b001: m_alu_op = ALU_MULH;
      3'b010: m_alu_op = ALU_MULHSU;
      3'b011: m_alu_op = ALU_MULHU;
      3'b100: m_alu_op = ALU_DIV;
      3'b101: m_alu_op = ALU_DIVU;
      3'b110: m_alu_op = ALU_REM;
      3'b111: m_alu_op = ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(M) decoder: instruction word to control bundle,
// register-use flags and illegal-instruction flag.
module decode_comb
  import decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  ctrl_t       c;
  logic        ill;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}},
                  instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31],
                  instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    c   = '0;
    ill = 1'b0;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        c.imm        = imm_u;
        c.reg_write  = 1'b1;
        c.result_mux = RES_IMM;
      end
      (opc == OPC_AUIPC): begin
        c.imm       = imm_u;
        c.alu_op    = ALU_ADD;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 1'b1;
        c.reg_write = 1'b1;
      end
      (opc == OPC_OP): begin
        c.reg_write = 1'b1;
        if (f7 == F7_MULDIV) begin
          c.alu_op = m_alu_op(f3);
          ill      = !ENABLE_M;
        end else begin
          c.alu_op = {1'b0, f7[5], f3};
          ill = !((f7 == F7_BASE) ||
                  (f7 == F7_ALT &&
                   (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      (opc == OPC_OP_IMM): begin
        c.imm       = imm_i;
        c.alu_src_b = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = {1'b0, (f3 == 3'b101) & f7[5], f3};
        ill = (f3 == 3'b001 && f7 != F7_BASE) ||
              (f3 == 3'b101 && f7 != F7_BASE &&
               f7 != F7_ALT);
      end
      (opc == OPC_LOAD): begin
        c.imm        = imm_i;
        c.alu_op     = ALU_ADD;
        c.alu_src_b  = 1'b1;
        c.reg_write  = 1'b1;
        c.result_mux = RES_MEM;
        c.mem_read   = 1'b1;
        c.mem_mask   = lane_mask(f3[1:0]);
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      (opc == OPC_STORE): begin
        c.imm       = imm_s;
        c.alu_op    = ALU_ADD;
        c.alu_src_b = 1'b1;
        c.mem_write = 1'b1;
        c.mem_mask  = lane_mask(f3[1:0]);
        ill = f3[2] || (f3 == 3'b011);
      end
      (opc == OPC_BRANCH): begin
        c.imm       = imm_b;
        c.alu_op    = ALU_SUB;
        c.branch    = 1'b1;
        c.branch_op = f3;
        ill = (f3[2:1] == 2'b01);
      end
      (opc == OPC_JAL): begin
        c.imm        = imm_j;
        c.alu_op     = ALU_ADD;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 1'b1;
        c.reg_write  = 1'b1;
        c.result_mux = RES_PC4;
        c.jump       = 1'b1;
      end
      (opc == OPC_JALR): begin
        c.imm        = imm_i;
        c.alu_op     = ALU_ADD;
        c.alu_src_b  = 1'b1;
        c.reg_write  = 1'b1;
        c.result_mux = RES_PC4;
        c.jump       = 1'b1;
        c.jalr       = 1'b1;
        ill = (f3 != 3'b000);
      end
      (opc == OPC_MISC_MEM): begin
        c.imm = imm_i;
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;
    // Illegal ops still flow downstream, but must not touch state
    if (ill) begin
      c.reg_write = 1'b0;
      c.mem_read  = 1'b0;
      c.mem_write = 1'b0;
      c.branch    = 1'b0;
      c.jump      = 1'b0;
    end
    c.illegal = ill;
  end

  assign ctrl_o    = c;
  assign use_rs1_o = !(opc == OPC_LUI || opc == OPC_AUIPC ||
                       opc == OPC_JAL || opc == OPC_MISC_MEM);
  assign use_rs2_o = (opc == OPC_OP) || (opc == OPC_STORE) ||
                     (opc == OPC_BRANCH);

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32I(M) decode stage (ID/EX register) with
// flush, back-pressure and load-use stall insertion.
module decode_stage
  import decode_pkg::*;
#(
  parameter bit ENABLE_M         = 1'b1,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int ALU_OP_W         = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instr,
  input  logic [31:0]         i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_pc,
  output logic [6:0]          o_opcode,
  output logic [2:0]          o_funct3,
  output logic [4:0]          o_rs1_addr,
  output logic [4:0]          o_rs2_addr,
  output logic [4:0]          o_rd_addr,
  output logic [31:0]         o_imm,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_alu_src_a,
  output logic                o_alu_src_b,
  output logic                o_reg_write,
  output logic [1:0]          o_result_mux,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [3:0]          o_mem_mask,
  output logic                o_branch,
  output logic [2:0]          o_branch_op,
  output logic                o_jump,
  output logic                o_jalr,
  output logic                o_illegal
);

  localparam int CW = (LOAD_USE_BUBBLES > 0) ?
                      $clog2(LOAD_USE_BUBBLES + 1) : 1;

  ctrl_t         ctrl;
  logic          use_rs1;
  logic          use_rs2;
  id_ex_t        bundle_d, bundle_q;
  logic          valid_d, valid_q;
  logic [4:0]    shadow_rd_d, shadow_rd_q;
  logic [CW-1:0] shadow_cnt_d, shadow_cnt_q;
  logic [4:0]    rs1, rs2;
  logic          ld_hold, sh_live;
  logic          rs1_hit, rs2_hit;
  logic          hazard;
  logic          fire_in, fire_out;

  decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_comb (
    .instr_i   (i_instr),
    .ctrl_o    (ctrl),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2)
  );

  assign rs1 = i_instr[19:15];
  assign rs2 = i_instr[24:20];

  assign ld_hold = valid_q && bundle_q.ctrl.mem_read;
  assign sh_live = (shadow_cnt_q != '0);

  assign rs1_hit = use_rs1 && (rs1 != 5'd0) &&
                   ((ld_hold && rs1 == bundle_q.rd) ||
                    (sh_live && rs1 == shadow_rd_q));
  assign rs2_hit = use_rs2 && (rs2 != 5'd0) &&
                   ((ld_hold && rs2 == bundle_q.rd) ||
                    (sh_live && rs2 == shadow_rd_q));

  assign hazard = (LOAD_USE_BUBBLES > 0) && i_valid &&
                  (rs1_hit || rs2_hit);

  assign o_ready  = (!valid_q || i_ready) && !hazard;
  assign fire_in  = i_valid && o_ready;
  assign fire_out = valid_q && i_ready;

  always_comb begin
    valid_d      = valid_q;
    bundle_d     = bundle_q;
    shadow_rd_d  = shadow_rd_q;
    shadow_cnt_d = shadow_cnt_q;
    if (sh_live) shadow_cnt_d = shadow_cnt_q - 1'b1;
    // A departing load re-arms the shadow for the bubbles it still needs
    if (fire_out && bundle_q.ctrl.mem_read &&
        bundle_q.rd != 5'd0) begin
      shadow_rd_d  = bundle_q.rd;
      shadow_cnt_d = CW'(LOAD_USE_BUBBLES);
    end
    if (fire_out) valid_d = 1'b0;
    if (fire_in && !i_flush) begin
      valid_d         = 1'b1;
      bundle_d.pc     = i_pc;
      bundle_d.opcode = i_instr[6:0];
      bundle_d.funct3 = i_instr[14:12];
      bundle_d.rs1    = rs1;
      bundle_d.rs2    = rs2;
      bundle_d.rd     = i_instr[11:7];
      bundle_d.ctrl   = ctrl;
    end
    if (i_flush) begin
      valid_d      = 1'b0;
      shadow_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      bundle_q     <= '0;
      shadow_rd_q  <= 5'd0;
      shadow_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      bundle_q     <= bundle_d;
      shadow_rd_q  <= shadow_rd_d;
      shadow_cnt_q <= shadow_cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_pc         = bundle_q.pc;
  assign o_opcode     = bundle_q.opcode;
  assign o_funct3     = bundle_q.funct3;
  assign o_rs1_addr   = bundle_q.rs1;
  assign o_rs2_addr   = bundle_q.rs2;
  assign o_rd_addr    = bundle_q.rd;
  assign o_imm        = bundle_q.ctrl.imm;
  assign o_alu_op     = bundle_q.ctrl.alu_op[ALU_OP_W-1:0];
  assign o_alu_src_a  = bundle_q.ctrl.alu_src_a;
  assign o_alu_src_b  = bundle_q.ctrl.alu_src_b;
  assign o_reg_write  = bundle_q.ctrl.reg_write;
  assign o_result_mux = bundle_q.ctrl.result_mux;
  assign o_mem_read   = bundle_q.ctrl.mem_read;
  assign o_mem_write  = bundle_q.ctrl.mem_write;
  assign o_mem_mask   = bundle_q.ctrl.mem_mask;
  assign o_branch     = bundle_q.ctrl.branch;
  assign o_branch_op  = bundle_q.ctrl.branch_op;
  assign o_jump       = bundle_q.ctrl.jump;
  assign o_jalr       = bundle_q.ctrl.jalr;
  assign o_illegal    = bundle_q.ctrl.illegal;

endmodule
